ps2_move_cmd_decoder: RTL and testbench

//   Turns PS/2 set-2 scancode bytes into the player movement strobes forward/backward/rotateA/rotateD.

---
 rtl/ps2_move_cmd_decoder.sv | 155 +++++++++++++++
 tb/tb_ps2_move_cmd_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_move_cmd_decoder.sv
// PS/2 set-2 scancode decoder producing rate-limited movement strobes.
// Ports: clock, resetn, ps2_byte/ps2_valid in; forward/backward/rotateA/rotateD
// one-cycle pulses and keys_held {W,S,A,D} out. Optional macro ARROW_KEYS_EN
// aliases extended arrow codes E0 75/72/6B/74 onto W/S/A/D.
module ps2_move_cmd_decoder #(
    parameter int         STEP_CYCLES = 2500000,
    parameter logic [7:0] KEY_W       = 8'h1D,
    parameter logic [7:0] KEY_S       = 8'h1B,
    parameter logic [7:0] KEY_A       = 8'h1C,
    parameter logic [7:0] KEY_D       = 8'h23
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] ps2_byte,
    input  logic       ps2_valid,
    output logic       forward,
    output logic       backward,
    output logic       rotateA,
    output logic       rotateD,
    output logic [3:0] keys_held
);

    localparam logic [7:0] BYTE_BRK = 8'hF0;
    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BAT = 8'hAA;
    localparam int         CW       = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_BWD} dir_t;

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [3:0]    held_q, held_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    std_mask, ext_mask;
    logic          fwd_d, bwd_d, rota_d, rotd_d;

    // One-hot {W,S,A,D} flag selected by a plain scancode
    always_comb begin
        std_mask = 4'b0000;
        unique case (1'b1)
            (ps2_byte == KEY_W): std_mask = 4'b1000;
            (ps2_byte == KEY_S): std_mask = 4'b0100;
            (ps2_byte == KEY_A): std_mask = 4'b0010;
            (ps2_byte == KEY_D): std_mask = 4'b0001;
            default:             std_mask = 4'b0000;
        endcase
    end

`ifdef ARROW_KEYS_EN
    // Arrows share the held flag of their letter key
    always_comb begin
        ext_mask = 4'b0000;
        unique case (1'b1)
            (ps2_byte == 8'h75): ext_mask = 4'b1000;
            (ps2_byte == 8'h72): ext_mask = 4'b0100;
            (ps2_byte == 8'h6B): ext_mask = 4'b0010;
            (ps2_byte == 8'h74): ext_mask = 4'b0001;
            default:             ext_mask = 4'b0000;
        endcase
    end
`else
    assign ext_mask = 4'b0000;
`endif

    // Parser: next state and next held flags
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        if (ps2_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (ps2_byte == BYTE_BRK)      state_d = BRK;
                    else if (ps2_byte == BYTE_EXT) state_d = EXT;
                    else if (ps2_byte == BYTE_BAT) held_d = 4'b0000;
                    else                           held_d = held_q | std_mask;
                end
                BRK: begin
                    if (ps2_byte == BYTE_EXT) begin
                        state_d = EXT;
                    end else begin
                        held_d  = held_q & ~std_mask;
                        state_d = IDLE;
                    end
                end
                EXT: begin
                    if (ps2_byte == BYTE_BRK) begin
                        state_d = EXT_BRK;
                    end else begin
                        held_d  = held_q | ext_mask;
                        state_d = IDLE;
                    end
                end
                EXT_BRK: begin
                    held_d  = held_q & ~ext_mask;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Direction and step-rate pulse generation from the next held flags,
    // so pulses line up with the keys_held update.
    always_comb begin
        dir_d = DIR_NONE;
        if (held_d[3] && !held_d[2])      dir_d = DIR_FWD;
        else if (held_d[2] && !held_d[3]) dir_d = DIR_BWD;

        cnt_d = '0;
        fwd_d = 1'b0;
        bwd_d = 1'b0;
        if (dir_d != DIR_NONE) begin
            if (dir_d != dir_q) begin
                fwd_d = (dir_d == DIR_FWD);
                bwd_d = (dir_d == DIR_BWD);
            end else if (cnt_q == CNT_MAX) begin
                fwd_d = (dir_d == DIR_FWD);
                bwd_d = (dir_d == DIR_BWD);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Rotation fires only on a fresh press with the other rotate key up
        rota_d = held_d[1] && !held_q[1] && !held_d[0];
        rotd_d = held_d[0] && !held_q[0] && !held_d[1];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            dir_q    <= DIR_NONE;
            held_q   <= 4'b0000;
            cnt_q    <= '0;
            forward  <= 1'b0;
            backward <= 1'b0;
            rotateA  <= 1'b0;
            rotateD  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            held_q   <= held_d;
            cnt_q    <= cnt_d;
            forward  <= fwd_d;
            backward <= bwd_d;
            rotateA  <= rota_d;
            rotateD  <= rotd_d;
        end
    end

    assign keys_held = held_q;

endmodule

// File: tb/tb_ps2_move_cmd_decoder.sv
// Directed testbench for ps2_move_cmd_decoder with STEP_CYCLES=8.
// Inputs change after negedge; outputs are sampled on negedge.
module tb_ps2_move_cmd_decoder;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_valid = 1'b0;
    logic       forward, backward, rotateA, rotateD;
    logic [3:0] keys_held;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_move_cmd_decoder #(.STEP_CYCLES(8)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .ps2_byte  (ps2_byte),
        .ps2_valid (ps2_valid),
        .forward   (forward),
        .backward  (backward),
        .rotateA   (rotateA),
        .rotateD   (rotateD),
        .keys_held (keys_held)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        resetn = 1'b0;
        ps2_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // Byte is accepted at the posedge inside; returns at the next negedge
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        ps2_byte = b;
        ps2_valid = 1'b1;
        @(negedge clock);
        ps2_valid = 1'b0;
    endtask

    // Count every pulse over n idle cycles
    task automatic quiet(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            pulses += int'(forward) + int'(backward)
                    + int'(rotateA) + int'(rotateD);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #12;
        chk("reset_fwd", {7'd0, forward}, 8'd0);
        chk("reset_bwd", {7'd0, backward}, 8'd0);
        chk("reset_rot", {6'd0, rotateA, rotateD}, 8'd0);
        chk("reset_held", {4'd0, keys_held}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic test_forward();
        int p, bad;
        apply_reset();
        send(8'h1D);
        chk("fwd_first", {7'd0, forward}, 8'd1);
        chk("fwd_held", {4'd0, keys_held}, 8'h08);
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (forward !== ((i % 8) == 0)) bad++;
            if (backward !== 1'b0) bad++;
        end
        chk("fwd_period", bad[7:0], 8'd0);
        send(8'hF0);
        send(8'h1D);
        chk("fwd_break_held", {4'd0, keys_held}, 8'h00);
        quiet(20, p);
        chk("fwd_stop", p[7:0], 8'd0);
    endtask

    task automatic test_both();
        int p, bad;
        apply_reset();
        send(8'h1D);
        send(8'h1B);
        chk("both_held", {4'd0, keys_held}, 8'h0C);
        quiet(20, p);
        chk("both_quiet", p[7:0], 8'd0);
        send(8'hF0);
        send(8'h1D);
        chk("bwd_first", {7'd0, backward}, 8'd1);
        chk("bwd_held", {4'd0, keys_held}, 8'h04);
        bad = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (backward !== ((i % 8) == 0)) bad++;
            if (forward !== 1'b0) bad++;
        end
        chk("bwd_period", bad[7:0], 8'd0);
    endtask

    task automatic test_rotate();
        int cnt;
        apply_reset();
        send(8'h1C);
        chk("rotA_first", {7'd0, rotateA}, 8'd1);
        chk("rotA_held", {4'd0, keys_held}, 8'h02);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'h1C);
            cnt += int'(rotateA);
        end
        chk("rotA_typematic", cnt[7:0], 8'd0);
        send(8'hF0);
        send(8'h1C);
        chk("rotA_break", {4'd0, keys_held}, 8'h00);
        send(8'h1C);
        chk("rotA_second", {7'd0, rotateA}, 8'd1);
        send(8'h23);
        chk("rotD_blocked", {7'd0, rotateD}, 8'd0);
        chk("rotAD_held", {4'd0, keys_held}, 8'h03);
    endtask

    task automatic test_arrow();
        apply_reset();
        send(8'h1D);
        send(8'hE0);
        send(8'h75);
        chk("arrow_make", {4'd0, keys_held}, 8'h08);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
`ifdef ARROW_KEYS_EN
        chk("arrow_break", {4'd0, keys_held}, 8'h00);
`else
        chk("arrow_break", {4'd0, keys_held}, 8'h08);
`endif
        send(8'hE0);
        send(8'h6B);
`ifdef ARROW_KEYS_EN
        chk("arrow_left", {6'd0, rotateA, keys_held[1]}, 8'h03);
`else
        chk("arrow_left", {6'd0, rotateA, keys_held[1]}, 8'h00);
`endif
    endtask

    task automatic test_bat_and_async_reset();
        int p;
        apply_reset();
        send(8'h1D);
        send(8'h1C);
        chk("bat_pre", {4'd0, keys_held}, 8'h0A);
        send(8'hAA);
        chk("bat_held", {4'd0, keys_held}, 8'h00);
        chk("bat_pulse", {4'd0, forward, backward, rotateA, rotateD}, 8'h00);
        quiet(20, p);
        chk("bat_quiet", p[7:0], 8'd0);
        send(8'h1D);
        send(8'h1C);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_held", {4'd0, keys_held}, 8'h00);
        chk("async_pulse", {4'd0, forward, backward, rotateA, rotateD}, 8'h00);
        @(negedge clock);
        resetn = 1'b1;
        quiet(20, p);
        chk("async_state_gone", p[7:0], 8'd0);
    endtask

    task automatic test_unmapped();
        apply_reset();
        send(8'hF0);
        send(8'h55);
        send(8'h1D);
        chk("unmapped_fwd", {7'd0, forward}, 8'd1);
        chk("unmapped_held", {4'd0, keys_held}, 8'h08);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clock);
        ps2_valid = 1'b1;
        ps2_byte = 8'h23;
        @(negedge clock);
        chk("b2b_rotD", {7'd0, rotateD}, 8'd1);
        ps2_byte = 8'hF0;
        @(negedge clock);
        ps2_byte = 8'h23;
        @(negedge clock);
        ps2_valid = 1'b0;
        chk("b2b_held", {4'd0, keys_held}, 8'h00);
    endtask

    initial begin
        test_reset();
        test_forward();
        test_both();
        test_rotate();
        test_arrow();
        test_bat_and_async_reset();
        test_unmapped();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
